scan_decoder: RTL



---
 rtl/scan_decoder_pkg.sv | 15 +
 rtl/onehot_dec.sv | 18 +
 rtl/scan_decoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan_decoder block.
//   state_t     : sequencer state, IDLE or SCAN
//   MODE_DIRECT : mode value that decodes the external select
//   MODE_SCAN   : mode value that arms the auto-scan sequencer
package scan_decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
//   sel    in  SEL_W  index to decode
//   en     in  1      low forces the whole output to zero
//   onehot out OUT_W  onehot[i] = en & (sel == i)
module onehot_dec #(
  parameter  int SEL_W = 2,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [OUT_W-1:0] onehot
);

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
    assign onehot[gi] = en && (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot select decoder with an auto-scan sequencer. Drives the
// per-tap / per-register select and write-enable lines of the filter datapath.
//   clk   in  1      rising-edge clock
//   rst_n in  1      asynchronous active-low reset
//   en    in  1      global enable; low zeroes out and pauses a scan
//   mode  in  1      MODE_DIRECT / MODE_SCAN, sampled only in IDLE
//   sel   in  SEL_W  index decoded in direct mode
//   start in  1      single-cycle scan request (IDLE only)
//   last  in  SEL_W  final scan index, latched at start
//   cont  in  1      wrap to index 0 instead of finishing
//   out   out OUT_W  registered one-hot or all-zero select
//   idx   out SEL_W  scan index most recently presented on out
//   busy  out 1      high while scanning
//   done  out 1      one-cycle pulse when a scan finishes
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter  int SEL_W = 2,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
  input  logic [SEL_W-1:0] last,
  input  logic             cont,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             busy,
  output logic             done
);

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   last_reg, last_next;
  logic [SEL_W-1:0]   idx_next;
  logic               busy_next, done_next;
  logic               dec_en;
  logic [SEL_W-1:0]   dec_sel;
  logic [OUT_W-1:0]   dec_out;

  // The decoder always sees the value out will take on the next edge, so
  // out can never be multi-hot, not even on a mode or state change.
  assign dec_sel = (state_next == SCAN) ? idx_next : sel;

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel    (dec_sel),
    .en     (dec_en),
    .onehot (dec_out)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx;
    last_next  = last_reg;
    busy_next  = busy;
    done_next  = 1'b0;
    dec_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mode == MODE_DIRECT) begin
          dec_en = en;
        end else if (start && en) begin
          idx_next   = '0;
          last_next  = last;
          busy_next  = 1'b1;
          state_next = SCAN;
          dec_en     = 1'b1;
        end
      end
      SCAN: begin
        // With en low idx holds and out goes to zero; the next enabled edge
        // presents the following index, so no index is skipped or repeated.
        if (en) begin
          if (idx != last_reg) begin
            idx_next = idx + SEL_W'(1);
            dec_en   = 1'b1;
          end else if (cont) begin
            idx_next = '0;
            dec_en   = 1'b1;
          end else begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= '0;
      idx       <= '0;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      idx       <= idx_next;
      out       <= dec_out;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

endmodule
